// File: rtl/sr_pulse_driver.sv
// Synchronous driver for the set/reset inputs of a NAND SR latch: synchronises requests, serialises
// them into fixed-width active-low pulses. Optional feedback check: define SR_DRIVER_FB_CHECK_EN.
module sr_pulse_driver #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
`ifdef SR_DRIVER_FB_CHECK_EN
    input  logic q_fb,
    output logic q_expect,
    output logic fb_fault,
`endif
    output logic s_n,
    output logic r_n,
    output logic busy,
    output logic done
);

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] set_sync_q, set_sync_d;
    logic [SYNC_STAGES-1:0] clr_sync_q, clr_sync_d;
    logic                   set_dly_q, set_dly_d;
    logic                   clr_dly_q, clr_dly_d;
    logic                   pend_set_q, pend_set_d;
    logic                   pend_clr_q, pend_clr_d;
    logic                   s_n_q, s_n_d;
    logic                   r_n_q, r_n_d;
    logic                   done_q, done_d;
    logic                   set_rise_s, clr_rise_s;
    logic                   dispatch_ok_s, disp_set_s, disp_clr_s;

    // Request synchronisers, rise detection and sticky pending flags
    always_comb begin
        set_sync_d = {set_sync_q[SYNC_STAGES-2:0], set_req};
        clr_sync_d = {clr_sync_q[SYNC_STAGES-2:0], clr_req};
        set_dly_d  = set_sync_q[SYNC_STAGES-1];
        clr_dly_d  = clr_sync_q[SYNC_STAGES-1];
        set_rise_s = set_sync_q[SYNC_STAGES-1] & ~set_dly_q;
        clr_rise_s = clr_sync_q[SYNC_STAGES-1] & ~clr_dly_q;
        // A rise on the dispatch edge re-arms the flag for a later pulse
        pend_set_d = (pend_set_q & ~disp_set_s) | set_rise_s;
        pend_clr_d = (pend_clr_q & ~disp_clr_s) | clr_rise_s;
    end

    // Pulse sequencer: next state, counter and output levels
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        s_n_d         = s_n_q;
        r_n_d         = r_n_q;
        done_d        = 1'b0;
        dispatch_ok_s = 1'b0;
        disp_set_s    = 1'b0;
        disp_clr_s    = 1'b0;
        case (state_q)
            IDLE: begin
                dispatch_ok_s = 1'b1;
            end
            PULSE: begin
                if (cnt_q == 8'd0) begin
                    s_n_d   = 1'b1;
                    r_n_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d       = IDLE;
                    dispatch_ok_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                s_n_d   = 1'b1;
                r_n_d   = 1'b1;
                cnt_d   = 8'd0;
            end
        endcase
        // Dispatch also fires on the edge GAP ends, so no idle cycle is inserted
        if (dispatch_ok_s) begin
            if (pend_clr_q) begin
                state_d    = PULSE;
                r_n_d      = 1'b0;
                cnt_d      = PULSE_LOAD;
                disp_clr_s = 1'b1;
            end else if (pend_set_q) begin
                state_d    = PULSE;
                s_n_d      = 1'b0;
                cnt_d      = PULSE_LOAD;
                disp_set_s = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            disp_set_s = 1'b0;
            disp_clr_s = 1'b0;
        end
    end

    // State, synchroniser and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            set_sync_q <= '0;
            clr_sync_q <= '0;
            set_dly_q  <= 1'b0;
            clr_dly_q  <= 1'b0;
            pend_set_q <= 1'b0;
            pend_clr_q <= 1'b1;
            s_n_q      <= 1'b1;
            r_n_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            set_sync_q <= set_sync_d;
            clr_sync_q <= clr_sync_d;
            set_dly_q  <= set_dly_d;
            clr_dly_q  <= clr_dly_d;
            pend_set_q <= pend_set_d;
            pend_clr_q <= pend_clr_d;
            s_n_q      <= s_n_d;
            r_n_q      <= r_n_d;
            done_q     <= done_d;
        end
    end

    assign s_n  = s_n_q;
    assign r_n  = r_n_q;
    assign done = done_q;
    assign busy = (state_q != IDLE) | pend_set_q | pend_clr_q;

`ifdef SR_DRIVER_FB_CHECK_EN
    logic q_expect_q, q_expect_d;
    logic fb_fault_q, fb_fault_d;

    // Expected latch state tracks the pulse just finished; mismatch checked on the last gap cycle
    always_comb begin
        q_expect_d = q_expect_q;
        fb_fault_d = fb_fault_q;
        if ((state_q == PULSE) && (cnt_q == 8'd0)) begin
            q_expect_d = ~s_n_q;
        end else begin
            q_expect_d = q_expect_q;
        end
        if ((state_q == GAP) && (cnt_q == 8'd0) && (q_fb != q_expect_q)) begin
            fb_fault_d = 1'b1;
        end else begin
            fb_fault_d = fb_fault_q;
        end
    end

    // Feedback check registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_expect_q <= 1'b0;
            fb_fault_q <= 1'b0;
        end else begin
            q_expect_q <= q_expect_d;
            fb_fault_q <= fb_fault_d;
        end
    end

    assign q_expect = q_expect_q;
    assign fb_fault = fb_fault_q;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: directed scenarios plus random requests, checked every cycle against a
// pulse-schedule reference model. Feedback checks compile when SR_DRIVER_FB_CHECK_EN is defined.
module tb_sr_pulse_driver;

    localparam int P = 2;
    localparam int G = 1;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic s_n, r_n, busy, done;
`ifdef SR_DRIVER_FB_CHECK_EN
    logic q_fb = 1'b0;
    logic q_expect, fb_fault;
`endif

    int checks = 0;
    int errors = 0;

    sr_pulse_driver #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_req (set_req),
        .clr_req (clr_req),
`ifdef SR_DRIVER_FB_CHECK_EN
        .q_fb    (q_fb),
        .q_expect(q_expect),
        .fb_fault(fb_fault),
`endif
        .s_n     (s_n),
        .r_n     (r_n),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Reference model: edge count since reset release, sampled request history, pending flags, pulse schedule
    int n;
    bit samp_s[$];
    bit samp_c[$];
    bit pend_s, pend_c;
    int next_free;
    int last_start;
    bit kind_set;
    bit qe, ff;

    task automatic model_reset();
        n = 0;
        samp_s.delete(); samp_c.delete();
        samp_s.push_back(1'b0); samp_c.push_back(1'b0);
        pend_s = 1'b0; pend_c = 1'b1;
        next_free = 1;
        last_start = -100;
        kind_set = 1'b0;
        qe = 1'b0; ff = 1'b0;
    endtask

    task automatic model_edge();
        bit new_s, new_c;
        n++;
        samp_s.push_back(set_req);
        samp_c.push_back(clr_req);
        new_s = (n - S >= 1) && samp_s[n-S] && !samp_s[n-S-1];
        new_c = (n - S >= 1) && samp_c[n-S] && !samp_c[n-S-1];
        if (n == last_start + P) qe = kind_set;
`ifdef SR_DRIVER_FB_CHECK_EN
        if ((n == last_start + P + G) && (q_fb != qe)) ff = 1'b1;
`endif
        if ((n >= next_free) && (pend_c || pend_s)) begin
            kind_set = !pend_c;
            if (pend_c) pend_c = 1'b0;
            else pend_s = 1'b0;
            last_start = n;
            next_free = n + P + G;
        end
        pend_s = pend_s | new_s;
        pend_c = pend_c | new_c;
    endtask

    function automatic bit exp_low(input bit want_set);
        return (n >= last_start) && (n < last_start + P) && (kind_set == want_set);
    endfunction

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b at edge %0d", tag, obs, expv, n);
        end
    endtask

    task automatic compare_all();
        check("s_n", s_n, !exp_low(1'b1));
        check("r_n", r_n, !exp_low(1'b0));
        check("done", done, n == last_start + P);
        check("busy", busy, (n < next_free) || pend_s || pend_c);
        check("never_both_low", s_n | r_n, 1'b1);
`ifdef SR_DRIVER_FB_CHECK_EN
        check("q_expect", q_expect, qe);
        check("fb_fault", fb_fault, ff);
`endif
    endtask

    // One clock: inputs driven well before the edge, outputs checked 1ns after it
    task automatic step(input bit sreq, input bit creq);
        set_req = sreq;
        clr_req = creq;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted mid-cycle, held for a few edges, released away from the edge
    task automatic do_reset(input int hold);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_s_n", s_n, 1'b1);
        check("rst_r_n", r_n, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b1);
        for (int i = 0; i < hold; i++) step(set_req, clr_req);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        rst_n = 1'b1;

        // Post-reset clear pulse
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

        // Single-cycle set request
        step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // Simultaneous set and clear rises
        step(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

        // Three set rises during an active clear pulse
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Reset asserted while s_n is low
        step(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0);
            if (s_n === 1'b0) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_s_n_low observed timeout expected s_n=0 within 20 cycles");
        end
        do_reset(2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

        // Random request traffic with occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            bit ns, nc;
            ns = ($urandom_range(0, 3) == 0) ? !set_req : set_req;
            nc = ($urandom_range(0, 5) == 0) ? !clr_req : clr_req;
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
            step(ns, nc);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
